// File: rtl/fft_ser_pkg.sv
// Shared types and default widths for the FFT bin serializer.
// FFT_SER_SAT_EN selects saturating rather than wrapping narrowing.
package fft_ser_pkg;

    localparam int N_BINS_D    = 8;
    localparam int IN_W_D      = 9;
    localparam int OUT_W_D     = 8;
    localparam int MAG_SHIFT_D = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC_RE,
        ST_CALC_IM,
        ST_SEND
    } state_t;

    function automatic int ACC_W(input int in_w);
        return 2 * in_w + 1;
    endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Single shared signed squarer with load/accumulate control.
// Builds re^2 + im^2 over two cycles for one bin.
module fft_mag_sq
    import fft_ser_pkg::*;
#(
    parameter int IN_W = IN_W_D
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    accum,
    input  logic [IN_W-1:0]         operand,
    output logic [ACC_W(IN_W)-1:0]  acc
);

    localparam int AW = ACC_W(IN_W);

    logic signed [2*IN_W-1:0] sq;
    logic [AW-1:0]            sq_ext;

    // A square is never negative, so zero-extension is exact.
    assign sq     = $signed(operand) * $signed(operand);
    assign sq_ext = {1'b0, sq};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= sq_ext;
        end else if (accum) begin
            acc <= acc + sq_ext;
        end
    end

endmodule

// File: rtl/fft_bin_serializer.sv
// Streams |X[k]|^2 of one captured FFT frame, one bin per handshake.
// Define FFT_SER_SAT_EN for saturating narrowing; default wraps.
module fft_bin_serializer
    import fft_ser_pkg::*;
#(
    parameter int N_BINS    = N_BINS_D,
    parameter int IN_W      = IN_W_D,
    parameter int OUT_W     = OUT_W_D,
    parameter int MAG_SHIFT = MAG_SHIFT_D
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_valid,
    input  logic [N_BINS*IN_W-1:0]    bins_re,
    input  logic [N_BINS*IN_W-1:0]    bins_im,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [OUT_W-1:0]          out_data,
    output logic [$clog2(N_BINS)-1:0] out_idx,
    output logic                      out_last,
    output logic                      busy,
    output logic                      frame_drop
);

    localparam int AW    = ACC_W(IN_W);
    localparam int IDX_W = $clog2(N_BINS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

    state_t state;
    state_t state_nxt;

    logic [N_BINS*IN_W-1:0] re_q;
    logic [N_BINS*IN_W-1:0] im_q;
    logic [IDX_W-1:0]       idx;
    logic [AW-1:0]          acc;
    logic [IN_W-1:0]        operand;
    logic [OUT_W-1:0]       narrowed;
    logic                   load;
    logic                   accum;
    logic                   accept;
    logic                   xfer;

`ifdef FFT_SER_SAT_EN
    localparam logic [AW-1:0] OUT_MAX = AW'((1 << OUT_W) - 1);

    assign narrowed = ((acc >> MAG_SHIFT) > OUT_MAX) ? '1
                    : OUT_W'(acc >> MAG_SHIFT);
`else
    assign narrowed = OUT_W'(acc >> MAG_SHIFT);
`endif

    assign operand = (state == ST_CALC_IM) ? im_q[idx*IN_W +: IN_W]
                                           : re_q[idx*IN_W +: IN_W];

    fft_mag_sq #(
        .IN_W (IN_W)
    ) u_mag_sq (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .accum   (accum),
        .operand (operand),
        .acc     (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accum     = 1'b0;
        accept    = 1'b0;
        xfer      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (frame_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_CALC_RE;
                end
            end
            ST_CALC_RE: begin
                load      = 1'b1;
                state_nxt = ST_CALC_IM;
            end
            ST_CALC_IM: begin
                accum     = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = narrowed;
                out_idx   = idx;
                out_last  = (idx == LAST_IDX);
                if (out_ready) begin
                    xfer      = 1'b1;
                    state_nxt = out_last ? ST_IDLE : ST_CALC_RE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bins are captured once per frame; later frame_valid pulses only flag a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_q       <= '0;
            im_q       <= '0;
            idx        <= '0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= frame_valid && (state != ST_IDLE);
            if (accept) begin
                re_q <= bins_re;
                im_q <= bins_im;
                idx  <= '0;
            end else if (xfer && !out_last) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Scoreboard bench for fft_bin_serializer at default parameters.
// Expected magnitudes follow FFT_SER_SAT_EN as seen by this build.
module tb_fft_bin_serializer;

    localparam int NB = 8;
    localparam int IW = 9;

    logic             clk;
    logic             rst_n;
    logic             frame_valid;
    logic [NB*IW-1:0] bins_re;
    logic [NB*IW-1:0] bins_im;
    logic             out_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic [2:0]       out_idx;
    logic             out_last;
    logic             busy;
    logic             frame_drop;

    int tests = 0;
    int fails = 0;
    logic [11:0] sb[$];

    fft_bin_serializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .bins_re     (bins_re),
        .bins_im     (bins_im),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .frame_drop  (frame_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] exp_item(input int k, input logic [8:0] re,
                                             input logic [8:0] im);
        int r;
        int i;
        int s;
        int d;
        r = $signed(re);
        i = $signed(im);
        s = (r * r + i * i) >> 8;
`ifdef FFT_SER_SAT_EN
        d = (s > 255) ? 255 : s;
`else
        d = s & 255;
`endif
        return {3'(k), 8'(d), (k == NB - 1)};
    endfunction

    function automatic void push_frame(input logic [NB*IW-1:0] re,
                                       input logic [NB*IW-1:0] im);
        for (int k = 0; k < NB; k++)
            sb.push_back(exp_item(k, re[k*IW +: IW], im[k*IW +: IW]));
    endfunction

    task automatic drive_frame(input logic [NB*IW-1:0] re, input logic [NB*IW-1:0] im);
        @(posedge clk);
        #1;
        bins_re     = re;
        bins_im     = im;
        frame_valid = 1'b1;
        push_frame(re, im);
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({out_valid, out_data, out_idx, out_last, busy, frame_drop} !== 14'd0) begin
            fails++;
            $display("FAIL reset_in: got v=%0b d=%0d i=%0d l=%0b b=%0b fd=%0b, want all 0",
                     out_valid, out_data, out_idx, out_last, busy, frame_drop);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({out_valid, out_data, out_idx, out_last, busy, frame_drop} !== 14'd0) begin
            fails++;
            $display("FAIL reset_out: got v=%0b d=%0d b=%0b, want all 0",
                     out_valid, out_data, busy);
        end
    endtask

    task automatic test_single_bin();
        logic [NB*IW-1:0] re = '0;
        logic [NB*IW-1:0] im = '0;
        logic [11:0] e;
        int n = 0;
        int got = 0;
        re[8:0] = 9'd48;
        im[8:0] = 9'd64;
        out_ready = 1'b1;
        drive_frame(re, im);
        while (got < NB && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                e = sb.pop_front();
                if (got == 0) begin
                    tests++;
                    if (n !== 3) begin
                        fails++;
                        $display("FAIL t1_latency: got %0d cycles, want 3", n);
                    end
                end
                tests++;
                if ({out_idx, out_data, out_last} !== e) begin
                    fails++;
                    $display("FAIL t1_bin: got i=%0d d=%0d l=%0b, want i=%0d d=%0d l=%0b",
                             out_idx, out_data, out_last, e[11:9], e[8:1], e[0]);
                end
                got++;
            end
        end
        tests++;
        if (n !== 24) begin
            fails++;
            $display("FAIL t1_frame_len: got %0d cycles (%0d bins), want 24", n, got);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL t1_idle: got busy=%0b, want 0", busy);
        end
    endtask

    task automatic test_saturation();
        logic [NB*IW-1:0] v = {NB{9'h100}};
        logic [11:0] e;
        int n = 0;
        int got = 0;
        drive_frame(v, v);
        while (got < NB && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                e = sb.pop_front();
                tests++;
                if ({out_idx, out_data, out_last} !== e) begin
                    fails++;
                    $display("FAIL t2_sat: got i=%0d d=%0d l=%0b, want i=%0d d=%0d l=%0b",
                             out_idx, out_data, out_last, e[11:9], e[8:1], e[0]);
                end
                got++;
            end
        end
        tests++;
        if (got !== NB) begin
            fails++;
            $display("FAIL t2_timeout: got %0d bins, want %0d", got, NB);
        end
    endtask

    task automatic test_backpressure();
        logic [NB*IW-1:0] re = 72'({$urandom(), $urandom(), $urandom()});
        logic [NB*IW-1:0] im = 72'({$urandom(), $urandom(), $urandom()});
        logic [11:0] e;
        int n = 0;
        int got = 0;
        int hold = 0;
        drive_frame(re, im);
        while (got < NB && n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                if (out_idx == 3'd2 && hold < 5) begin
                    out_ready = 1'b0;
                    hold++;
                    tests++;
                    if ({out_idx, out_data, out_last} !== sb[0]) begin
                        fails++;
                        $display("FAIL t3_hold: got i=%0d d=%0d, want i=%0d d=%0d",
                                 out_idx, out_data, sb[0][11:9], sb[0][8:1]);
                    end
                end else begin
                    out_ready = 1'b1;
                    e = sb.pop_front();
                    tests++;
                    if ({out_idx, out_data, out_last} !== e) begin
                        fails++;
                        $display("FAIL t3_bin: got i=%0d d=%0d l=%0b, want i=%0d d=%0d l=%0b",
                                 out_idx, out_data, out_last, e[11:9], e[8:1], e[0]);
                    end
                    got++;
                end
            end
        end
        out_ready = 1'b1;
        tests++;
        if (got !== NB || hold !== 5) begin
            fails++;
            $display("FAIL t3_done: got %0d bins %0d holds, want %0d bins 5 holds",
                     got, hold, NB);
        end
    endtask

    task automatic test_frame_drop();
        logic [NB*IW-1:0] re = 72'({$urandom(), $urandom(), $urandom()});
        logic [NB*IW-1:0] im = 72'({$urandom(), $urandom(), $urandom()});
        logic [11:0] e;
        int n = 0;
        int got = 0;
        int chk = 0;
        int extra = 0;
        drive_frame(re, im);
        while (got < NB && n < 100) begin
            @(negedge clk);
            n++;
            if (chk == 1) begin
                frame_valid = 1'b0;
                tests++;
                if (frame_drop !== 1'b1) begin
                    fails++;
                    $display("FAIL t4_drop: got frame_drop=%0b, want 1", frame_drop);
                end
                chk = 2;
            end else if (chk == 2) begin
                tests++;
                if (frame_drop !== 1'b0) begin
                    fails++;
                    $display("FAIL t4_pulse: got frame_drop=%0b, want 0", frame_drop);
                end
                chk = 3;
            end
            if (out_valid) begin
                e = sb.pop_front();
                tests++;
                if ({out_idx, out_data, out_last} !== e) begin
                    fails++;
                    $display("FAIL t4_bin: got i=%0d d=%0d l=%0b, want i=%0d d=%0d l=%0b",
                             out_idx, out_data, out_last, e[11:9], e[8:1], e[0]);
                end
                got++;
                if (out_idx == 3'd4 && chk == 0) begin
                    bins_re     = ~re;
                    bins_im     = ~im;
                    frame_valid = 1'b1;
                    chk         = 1;
                end
            end
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        tests++;
        if (extra !== 0 || chk !== 3) begin
            fails++;
            $display("FAIL t4_ignored: got %0d extra bins, stage %0d, want 0 and 3", extra, chk);
        end
    endtask

    task automatic test_reset_midframe();
        logic [NB*IW-1:0] re = 72'({$urandom(), $urandom(), $urandom()});
        logic [NB*IW-1:0] im = 72'({$urandom(), $urandom(), $urandom()});
        logic [11:0] e;
        int n = 0;
        int got = 0;
        bit seen4 = 1'b0;
        drive_frame(re, im);
        while (!seen4 && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                e = sb.pop_front();
                tests++;
                if ({out_idx, out_data, out_last} !== e) begin
                    fails++;
                    $display("FAIL t5_pre: got i=%0d d=%0d, want i=%0d d=%0d",
                             out_idx, out_data, e[11:9], e[8:1]);
                end
                seen4 = (out_idx == 3'd4);
            end
        end
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL t5_calc_im: got busy=%0b valid=%0b, want 1 0", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_data, out_idx, out_last, busy, frame_drop} !== 14'd0) begin
            fails++;
            $display("FAIL t5_async: got v=%0b d=%0d b=%0b, want all 0",
                     out_valid, out_data, busy);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        re = 72'({$urandom(), $urandom(), $urandom()});
        im = 72'({$urandom(), $urandom(), $urandom()});
        drive_frame(re, im);
        n = 0;
        while (got < NB && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                e = sb.pop_front();
                tests++;
                if ({out_idx, out_data, out_last} !== e) begin
                    fails++;
                    $display("FAIL t5_post: got i=%0d d=%0d l=%0b, want i=%0d d=%0d l=%0b",
                             out_idx, out_data, out_last, e[11:9], e[8:1], e[0]);
                end
                got++;
            end
        end
        tests++;
        if (got !== NB) begin
            fails++;
            $display("FAIL t5_timeout: got %0d bins, want %0d", got, NB);
        end
    endtask

    task automatic test_back_to_back();
        logic [NB*IW-1:0] ra = 72'({$urandom(), $urandom(), $urandom()});
        logic [NB*IW-1:0] ia = 72'({$urandom(), $urandom(), $urandom()});
        logic [NB*IW-1:0] rb = 72'({$urandom(), $urandom(), $urandom()});
        logic [NB*IW-1:0] ib = 72'({$urandom(), $urandom(), $urandom()});
        logic [11:0] e;
        int n = 0;
        int got = 0;
        int low = 0;
        int st = 0;
        drive_frame(ra, ia);
        while (got < 2 * NB && n < 200) begin
            @(negedge clk);
            n++;
            if (st == 1) begin
                bins_re     = rb;
                bins_im     = ib;
                frame_valid = 1'b1;
                push_frame(rb, ib);
                st = 2;
            end else if (st == 2) begin
                frame_valid = 1'b0;
                tests++;
                if (frame_drop !== 1'b0) begin
                    fails++;
                    $display("FAIL t6_nodrop: got frame_drop=%0b, want 0", frame_drop);
                end
                st = 3;
            end
            if (out_valid) begin
                if (got > 0) begin
                    tests++;
                    if (low > 3) begin
                        fails++;
                        $display("FAIL t6_gap: got %0d idle cycles, want <= 3", low);
                    end
                end
                low = 0;
                e = sb.pop_front();
                tests++;
                if ({out_idx, out_data, out_last} !== e) begin
                    fails++;
                    $display("FAIL t6_bin: got i=%0d d=%0d l=%0b, want i=%0d d=%0d l=%0b",
                             out_idx, out_data, out_last, e[11:9], e[8:1], e[0]);
                end
                got++;
                if (got == NB) st = 1;
            end else begin
                low++;
            end
        end
        tests++;
        if (got !== 2 * NB) begin
            fails++;
            $display("FAIL t6_timeout: got %0d bins, want %0d", got, 2 * NB);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_valid = 1'b0;
        out_ready   = 1'b1;
        bins_re     = '0;
        bins_im     = '0;
        test_reset();
        test_single_bin();
        test_saturation();
        test_backpressure();
        test_frame_drop();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
